// File: rtl/div_rem_unit.sv
// div_rem_unit: iterative RV32M divider (DIV/DIVU/REM/REMU) for the EX stage.
// Radix-2 restoring divide, one quotient bit per cycle. Divide-by-zero and
// signed overflow resolve on a single-cycle fast path.
//
// Ports:
//   clk, reset         core clock (rising edge), synchronous active-high reset
//   div_valid          EX stage holds a valid divide/remainder instruction
//   div_op             funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1_data/rs2_data  dividend / divisor (post-forwarding)
//   kill               abort the in-flight op (EX flush)
//   hold               EX frozen; result must stay stable, not consumed
//   exe_stall_div_rem  divide not complete: stall upstream, bubble EX
//   div_done           div_result valid this cycle
//   div_result         registered quotient or remainder
//   busy               iterating
module div_rem_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            div_valid,
   input  logic [1:0]      div_op,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            kill,
   input  logic            hold,
   output logic            exe_stall_div_rem,
   output logic            div_done,
   output logic [XLEN-1:0] div_result,
   output logic            busy
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [XLEN-1:0]   rem_reg, rem_next;
   logic [XLEN-1:0]   quot_reg, quot_next;
   logic [XLEN-1:0]   dvsr_reg, dvsr_next;
   logic [XLEN-1:0]   result_reg, result_next;
   logic              is_rem_reg, is_rem_next;
   logic              neg_q_reg, neg_q_next;
   logic              neg_r_reg, neg_r_next;

   // Operand preparation for the accept cycle
   logic              op_signed, op_rem, sign1, sign2, overflow;
   logic [XLEN-1:0]   abs1, abs2;

   assign op_signed = ~div_op[0];
   assign op_rem    = div_op[1];
   assign sign1     = op_signed & rs1_data[XLEN-1];
   assign sign2     = op_signed & rs2_data[XLEN-1];
   // Negating MIN_NEG wraps to itself, which is the correct unsigned magnitude
   assign abs1      = sign1 ? (~rs1_data + 1'b1) : rs1_data;
   assign abs2      = sign2 ? (~rs2_data + 1'b1) : rs2_data;
   assign overflow  = op_signed && (rs1_data == MIN_NEG) && (rs2_data == {XLEN{1'b1}});

   // One restoring step: the dividend is pre-loaded into quot and shifts
   // into rem from the top while quotient bits enter at the bottom.
   logic [XLEN:0]     rem_sh, diff;
   logic              ge;
   logic [XLEN-1:0]   rem_step, quot_step, q_fix, r_fix;

   assign rem_sh    = {rem_reg, quot_reg[XLEN-1]};
   assign diff      = rem_sh - {1'b0, dvsr_reg};
   assign ge        = ~diff[XLEN];
   assign rem_step  = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
   assign quot_step = {quot_reg[XLEN-2:0], ge};
   assign q_fix     = neg_q_reg ? (~quot_step + 1'b1) : quot_step;
   assign r_fix     = neg_r_reg ? (~rem_step + 1'b1) : rem_step;

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      rem_next    = rem_reg;
      quot_next   = quot_reg;
      dvsr_next   = dvsr_reg;
      result_next = result_reg;
      is_rem_next = is_rem_reg;
      neg_q_next  = neg_q_reg;
      neg_r_next  = neg_r_reg;
      if (kill) begin
         // Abort wins everywhere; the previous result stays visible
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (div_valid) begin
                  is_rem_next = op_rem;
                  neg_q_next  = sign1 ^ sign2;
                  neg_r_next  = sign1;
                  if (rs2_data == '0) begin
                     result_next = op_rem ? rs1_data : {XLEN{1'b1}};
                     state_next  = DONE;
                  end else if (overflow) begin
                     result_next = op_rem ? '0 : MIN_NEG;
                     state_next  = DONE;
                  end else begin
                     rem_next   = '0;
                     quot_next  = abs1;
                     dvsr_next  = abs2;
                     cnt_next   = CNT_W'(XLEN);
                     state_next = BUSY;
                  end
               end
            end
            BUSY: begin
               if (!div_valid) begin
                  state_next = IDLE;
               end else begin
                  rem_next  = rem_step;
                  quot_next = quot_step;
                  cnt_next  = cnt_reg - 1'b1;
                  if (cnt_reg == CNT_W'(1)) begin
                     result_next = is_rem_reg ? r_fix : q_fix;
                     state_next  = DONE;
                  end
               end
            end
            DONE: begin
               if (!hold) state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         rem_reg    <= '0;
         quot_reg   <= '0;
         dvsr_reg   <= '0;
         result_reg <= '0;
         is_rem_reg <= 1'b0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         rem_reg    <= rem_next;
         quot_reg   <= quot_next;
         dvsr_reg   <= dvsr_next;
         result_reg <= result_next;
         is_rem_reg <= is_rem_next;
         neg_q_reg  <= neg_q_next;
         neg_r_reg  <= neg_r_next;
      end
   end

   // Combinational so the stall appears in the same cycle the op enters EX
   assign exe_stall_div_rem = div_valid & (state_reg != DONE) & ~kill;
   assign div_done          = (state_reg == DONE);
   assign busy              = (state_reg == BUSY);
   assign div_result        = result_reg;

endmodule

// File: tb/tb_div_rem_unit.sv
// Scoreboard bench for div_rem_unit: stimulus pushes hand-computed expected
// results; a monitor pops one on each rising div_done and compares.
module tb_div_rem_unit;
   logic        clk = 1'b0;
   logic        reset, div_valid, kill, hold;
   logic [1:0]  div_op;
   logic [31:0] rs1_data, rs2_data;
   logic        exe_stall_div_rem, div_done, busy;
   logic [31:0] div_result;

   localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

   div_rem_unit #(.XLEN(32), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .div_valid(div_valid), .div_op(div_op),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .kill(kill), .hold(hold),
      .exe_stall_div_rem(exe_stall_div_rem), .div_done(div_done),
      .div_result(div_result), .busy(busy)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic        prev_done = 1'b0;
   logic [31:0] mon_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Monitor: one pop per completed transaction
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if ((div_done === 1'b1) && !prev_done) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_done: got result %h, required no completion", div_result);
            end else begin
               mon_exp = exp_q.pop_front();
               $display("done: result %h expected %h", div_result, mon_exp);
               check("result", div_result, mon_exp);
            end
         end
         prev_done = (div_done === 1'b1);
      end
   end

   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_v, input int exp_stall, input int hold_n);
      int cyc, n;
      @(negedge clk);
      div_valid = 1'b1; div_op = op; rs1_data = a; rs2_data = b;
      exp_q.push_back(exp_v);
      #1;
      check("idle_at_accept", {30'b0, busy, div_done}, 32'd0);
      cyc = 0; n = 0;
      while (!div_done && n < 100) begin
         if (exe_stall_div_rem) cyc++;
         n++;
         @(negedge clk);
         #1;
      end
      if (!div_done) begin
         checks++; errors++;
         $display("FAIL timeout: got no div_done after %0d cycles, required completion", n);
         div_valid = 1'b0;
         return;
      end
      check("stall_cycles", cyc, exp_stall);
      check("stall_at_done", {31'b0, exe_stall_div_rem}, 32'd0);
      if (hold_n > 0) begin
         hold = 1'b1;
         for (int i = 1; i < hold_n; i++) begin
            @(negedge clk);
            #1;
            check("hold_done", {31'b0, div_done}, 32'd1);
            check("hold_result", div_result, exp_v);
            check("hold_stall", {31'b0, exe_stall_div_rem}, 32'd0);
         end
         @(negedge clk);
         hold = 1'b0;
         #1;
         check("hold_release_done", {31'b0, div_done}, 32'd1);
      end
      div_valid = 1'b0;
   endtask

   initial begin
      int done_seen;
      reset = 1'b1; div_valid = 1'b0; kill = 1'b0; hold = 1'b0;
      div_op = 2'b00; rs1_data = '0; rs2_data = '0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_outputs", {29'b0, busy, div_done, exe_stall_div_rem}, 32'd0);
      check("reset_result", div_result, 32'd0);
      reset = 1'b0;

      do_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
      do_op(OP_REMU, 32'd100, 32'd7, 32'd2, 33, 0);
      do_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
      do_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
      do_op(OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
      do_op(OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0);
      do_op(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
      do_op(OP_REMU, 32'd5, 32'd0, 32'd5, 1, 0);
      do_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
      do_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
      do_op(OP_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, 0);
      do_op(OP_DIV,  32'h8000_0000, 32'd1, 32'h8000_0000, 33, 0);

      // Kill on BUSY cycle 10
      @(negedge clk);
      div_valid = 1'b1; div_op = OP_DIVU; rs1_data = 32'hFFFF_FFFF; rs2_data = 32'd1;
      repeat (10) @(negedge clk);
      kill = 1'b1;
      #1;
      check("kill_busy_before", {31'b0, busy}, 32'd1);
      check("kill_stall", {31'b0, exe_stall_div_rem}, 32'd0);
      @(negedge clk);
      kill = 1'b0; div_valid = 1'b0;
      #1;
      check("kill_idle", {30'b0, busy, div_done}, 32'd0);
      check("kill_result_kept", div_result, 32'h8000_0000);
      done_seen = 0;
      repeat (40) begin
         @(negedge clk);
         #1;
         if (div_done) done_seen++;
      end
      check("kill_no_done", done_seen, 32'd0);
      do_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 33, 0);

      // Hold for 3 DONE cycles, then back-to-back divide
      do_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 3);
      do_op(OP_DIV,  32'd20, 32'd4, 32'd5, 33, 0);

      // Reset on BUSY cycle 5
      @(negedge clk);
      div_valid = 1'b1; div_op = OP_DIVU; rs1_data = 32'd100; rs2_data = 32'd7;
      repeat (5) @(negedge clk);
      reset = 1'b1; div_valid = 1'b0;
      @(negedge clk);
      #1;
      check("midreset_outputs", {29'b0, busy, div_done, exe_stall_div_rem}, 32'd0);
      check("midreset_result", div_result, 32'd0);
      reset = 1'b0;
      do_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);

      repeat (3) @(negedge clk);
      check("queue_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
